// File: rtl/wb_stage_pipelined_if.sv
// MEM-to-WB bus for the write-back stage: captured instruction fields in,
// register-file write port and retire counter out.
interface wb_stage_pipelined_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned COUNT_WIDTH    = 32
);
  logic                      in_valid;
  logic                      in_stall;
  logic                      in_flush;
  logic                      in_mem_to_reg;
  logic                      in_reg_write;
  logic [1:0]                in_load_size;
  logic                      in_load_unsigned;
  logic [REG_ADDR_WIDTH-1:0] in_write_back_destination;
  logic [DATA_WIDTH-1:0]     in_alu_result;
  logic [DATA_WIDTH-1:0]     in_read_data;

  logic [DATA_WIDTH-1:0]     write_data_out;
  logic                      reg_write_out;
  logic [REG_ADDR_WIDTH-1:0] write_back_destination_out;
  logic                      wb_valid_out;
  logic [COUNT_WIDTH-1:0]    retired_count;

  modport master (
    output in_valid, in_stall, in_flush, in_mem_to_reg, in_reg_write,
           in_load_size, in_load_unsigned, in_write_back_destination,
           in_alu_result, in_read_data,
    input  write_data_out, reg_write_out, write_back_destination_out,
           wb_valid_out, retired_count
  );

  modport slave (
    input  in_valid, in_stall, in_flush, in_mem_to_reg, in_reg_write,
           in_load_size, in_load_unsigned, in_write_back_destination,
           in_alu_result, in_read_data,
    output write_data_out, reg_write_out, write_back_destination_out,
           wb_valid_out, retired_count
  );
endinterface

// File: rtl/wb_stage_pipelined.sv
// MIPS write-back stage: MEM/WB register with sub-word load formatting,
// stall/flush control, register-0 write suppression and a retire counter.
module wb_stage_pipelined #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned REG_ADDR_WIDTH    = 5,
  parameter bit          ZERO_REG_SUPPRESS = 1'b1,
  parameter int unsigned COUNT_WIDTH       = 32
) (
  input logic                clk,
  input logic                reset_n,
  wb_stage_pipelined_if.slave wb
);

  logic [1:0]                offset;
  logic [7:0]                byte_lane;
  logic [15:0]               half_lane;
  logic                      ext_bit;
  logic [DATA_WIDTH-1:0]     load_data;
  logic [DATA_WIDTH-1:0]     sel_data;

  logic                      valid_q;
  logic                      reg_write_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic [COUNT_WIDTH-1:0]    count_q;
  logic                      retire;
  logic                      dest_is_zero;

  // Lane selection assumes a 32-bit word; halfword ignores offset[0].
  always_comb begin
    offset    = wb.in_alu_result[1:0];
    byte_lane = '0;
    case (offset)
      2'd0:    byte_lane = wb.in_read_data[7:0];
      2'd1:    byte_lane = wb.in_read_data[15:8];
      2'd2:    byte_lane = wb.in_read_data[23:16];
      default: byte_lane = wb.in_read_data[31:24];
    endcase
    half_lane = offset[1] ? wb.in_read_data[31:16] : wb.in_read_data[15:0];

    ext_bit   = 1'b0;
    load_data = wb.in_read_data;
    case (wb.in_load_size)
      2'b00: begin
        ext_bit   = ~wb.in_load_unsigned & byte_lane[7];
        load_data = {{(DATA_WIDTH-8){ext_bit}}, byte_lane};
      end
      2'b01: begin
        ext_bit   = ~wb.in_load_unsigned & half_lane[15];
        load_data = {{(DATA_WIDTH-16){ext_bit}}, half_lane};
      end
      default: load_data = wb.in_read_data;
    endcase

    sel_data = wb.in_mem_to_reg ? load_data : wb.in_alu_result;
  end

  assign retire = valid_q & ~wb.in_stall & ~wb.in_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      data_q      <= '0;
      dest_q      <= '0;
      count_q     <= '0;
    end else begin
      // Flush only clears valid; the held fields stay for observability.
      if (wb.in_flush) begin
        valid_q <= 1'b0;
      end else if (!wb.in_stall) begin
        valid_q     <= wb.in_valid;
        reg_write_q <= wb.in_reg_write;
        data_q      <= sel_data;
        dest_q      <= wb.in_write_back_destination;
      end
      if (retire) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign dest_is_zero                  = (dest_q == '0);
  assign wb.write_data_out             = data_q;
  assign wb.write_back_destination_out = dest_q;
  assign wb.wb_valid_out               = valid_q;
  assign wb.retired_count              = count_q;
  assign wb.reg_write_out              = valid_q & reg_write_q &
                                         ~(ZERO_REG_SUPPRESS & dest_is_zero);

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined: vector table plus stall/flush,
// counter-wrap and asynchronous-reset sequences.
module tb_wb_stage_pipelined;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  wb_stage_pipelined_if #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .COUNT_WIDTH(4)
  ) bus ();

  wb_stage_pipelined #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .ZERO_REG_SUPPRESS(1'b1),
    .COUNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wb(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, stall, flush, m2r, rw;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  dest;
    logic [31:0] alu, rd;
    logic [31:0] e_data;
    logic        e_rw;
    logic [4:0]  e_dest;
    logic        e_valid;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam int unsigned NVEC = 21;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic valid, logic stall, logic flush, logic m2r,
                              logic rw, logic [1:0] size, logic uns, logic [4:0] dest,
                              logic [31:0] alu, logic [31:0] rd, logic [31:0] e_data,
                              logic e_rw, logic [4:0] e_dest, logic e_valid,
                              logic [3:0] e_cnt);
    vec_t v;
    v.valid = valid; v.stall = stall; v.flush = flush; v.m2r = m2r; v.rw = rw;
    v.size = size; v.uns = uns; v.dest = dest; v.alu = alu; v.rd = rd;
    v.e_data = e_data; v.e_rw = e_rw; v.e_dest = e_dest; v.e_valid = e_valid;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid                  = v.valid;
    bus.in_stall                  = v.stall;
    bus.in_flush                  = v.flush;
    bus.in_mem_to_reg             = v.m2r;
    bus.in_reg_write              = v.rw;
    bus.in_load_size              = v.size;
    bus.in_load_unsigned          = v.uns;
    bus.in_write_back_destination = v.dest;
    bus.in_alu_result             = v.alu;
    bus.in_read_data              = v.rd;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] data, input logic rw,
                         input logic [4:0] dest, input logic valid, input logic [3:0] cnt);
    chk({tag, " data"},  bus.write_data_out, data);
    chk({tag, " rw"},    32'(bus.reg_write_out), 32'(rw));
    chk({tag, " dest"},  32'(bus.write_back_destination_out), 32'(dest));
    chk({tag, " valid"}, 32'(bus.wb_valid_out), 32'(valid));
    chk({tag, " count"}, 32'(bus.retired_count), 32'(cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;

    //             vld stl fl m2r rw size uns dst alu          rd            e_data       e_rw e_dst e_v cnt
    vecs[0]  = mk(1, 0, 0, 0, 1, 2'b10, 0, 5, 32'h0000_1234, 32'h0,        32'h0000_1234, 1, 5, 1, 0);
    vecs[1]  = mk(1, 0, 0, 1, 1, 2'b00, 0, 6, 32'h0000_0003, 32'h80FF_7F01, 32'hFFFF_FF80, 1, 6, 1, 1);
    vecs[2]  = mk(1, 0, 0, 1, 1, 2'b00, 1, 6, 32'h0000_0003, 32'h80FF_7F01, 32'h0000_0080, 1, 6, 1, 2);
    vecs[3]  = mk(1, 0, 0, 1, 1, 2'b01, 0, 6, 32'h0000_0002, 32'h8001_1234, 32'hFFFF_8001, 1, 6, 1, 3);
    vecs[4]  = mk(1, 0, 0, 1, 1, 2'b01, 0, 6, 32'h0000_0001, 32'h8001_1234, 32'h0000_1234, 1, 6, 1, 4);
    vecs[5]  = mk(1, 0, 0, 1, 1, 2'b00, 0, 6, 32'h0000_0001, 32'h80FF_7F01, 32'h0000_007F, 1, 6, 1, 5);
    vecs[6]  = mk(1, 0, 0, 1, 1, 2'b00, 0, 6, 32'h0000_0002, 32'h80FF_7F01, 32'hFFFF_FFFF, 1, 6, 1, 6);
    vecs[7]  = mk(1, 0, 0, 1, 1, 2'b10, 0, 6, 32'h0000_0002, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 6, 1, 7);
    vecs[8]  = mk(1, 0, 0, 1, 1, 2'b11, 1, 6, 32'h0000_0003, 32'h1234_5678, 32'h1234_5678, 1, 6, 1, 8);
    vecs[9]  = mk(1, 0, 0, 1, 1, 2'b01, 1, 6, 32'h0000_0003, 32'h8001_1234, 32'h0000_8001, 1, 6, 1, 9);
    vecs[10] = mk(1, 0, 0, 0, 1, 2'b10, 0, 0, 32'h0000_AAAA, 32'h0,        32'h0000_AAAA, 0, 0, 1, 10);
    vecs[11] = mk(1, 0, 0, 0, 0, 2'b10, 0, 3, 32'h0000_0055, 32'h0,        32'h0000_0055, 0, 3, 1, 11);
    vecs[12] = mk(0, 0, 0, 0, 1, 2'b10, 0, 9, 32'h0000_0099, 32'h0,        32'h0000_0099, 0, 9, 0, 12);
    vecs[13] = mk(1, 0, 0, 0, 1, 2'b10, 0, 7, 32'h0000_0077, 32'h0,        32'h0000_0077, 1, 7, 1, 12);
    vecs[14] = mk(1, 1, 0, 0, 1, 2'b10, 0, 8, 32'h0000_0088, 32'h0,        32'h0000_0077, 1, 7, 1, 12);
    vecs[15] = mk(1, 1, 0, 0, 1, 2'b10, 0, 8, 32'h0000_0088, 32'h0,        32'h0000_0077, 1, 7, 1, 12);
    vecs[16] = mk(1, 1, 0, 0, 1, 2'b10, 0, 8, 32'h0000_0088, 32'h0,        32'h0000_0077, 1, 7, 1, 12);
    vecs[17] = mk(1, 1, 1, 0, 1, 2'b10, 0, 8, 32'h0000_0088, 32'h0,        32'h0000_0077, 0, 7, 0, 12);
    vecs[18] = mk(1, 0, 0, 0, 1, 2'b10, 0, 4, 32'h0000_0044, 32'h0,        32'h0000_0044, 1, 4, 1, 12);
    vecs[19] = mk(1, 0, 1, 0, 1, 2'b10, 0, 2, 32'h0000_0022, 32'h0,        32'h0000_0044, 0, 4, 0, 12);
    vecs[20] = mk(1, 0, 0, 0, 1, 2'b10, 0, 1, 32'h0000_0011, 32'h0,        32'h0000_0011, 1, 1, 1, 12);

    idle = mk(0, 0, 0, 0, 0, 2'b10, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);

    reset_n = 1'b0;
    drive(idle);
    repeat (2) @(negedge clk);
    chk_all("reset", 32'h0, 1'b0, 5'd0, 1'b0, 4'd0);
    reset_n = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_data, vecs[i].e_rw, vecs[i].e_dest,
              vecs[i].e_valid, vecs[i].e_cnt);
    end

    // Counter wrap: 16 retirements in a 4-bit counter return it to 0.
    @(negedge clk);
    drive(idle);
    reset_n = 1'b0;
    #1;
    chk("wrap reset count", 32'(bus.retired_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(mk(1, 0, 0, 0, 1, 2'b10, 0, 3, 32'h0000_0033, 32'h0, 32'h0, 0, 0, 0, 0));
    repeat (16) @(posedge clk);
    #1;
    chk("wrap count 15", 32'(bus.retired_count), 32'd15);
    @(posedge clk);
    #1;
    chk("wrap count 0", 32'(bus.retired_count), 32'd0);
    chk("wrap valid", 32'(bus.wb_valid_out), 32'd1);

    // Stall holds the instruction; an async reset between edges discards it.
    @(negedge clk);
    bus.in_stall = 1'b1;
    @(posedge clk);
    #1;
    chk("stall count", 32'(bus.retired_count), 32'd0);
    chk("stall rw", 32'(bus.reg_write_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async", 32'h0, 1'b0, 5'd0, 1'b0, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(idle);
    @(posedge clk);
    #1;
    chk("post reset valid", 32'(bus.wb_valid_out), 32'd0);
    chk("post reset count", 32'(bus.retired_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
